// File: rtl/alu_divider.sv
// Multi-cycle restoring divider (divu/div/remu/rem, op codes 20-23), one quotient bit per clock.
// Optional macro ALU_DIVIDER_EARLY_EXIT_EN skips leading-zero iterations of the dividend magnitude.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             is_zero,
    output logic             is_negative,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg;        // bit0: signed, bit1: remainder select
    logic [WIDTH-1:0] dvd_reg;       // dividend shifts out the top, quotient fills the bottom
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [CW-1:0]    count_reg;
    logic             q_sign_reg, r_sign_reg, dbz_reg;
    logic [WIDTH-1:0] c_reg;
    logic             is_zero_reg, is_negative_reg, div_by_zero_reg;

    logic             accept, op_signed, skip_run;
    logic [WIDTH-1:0] a_mag, b_mag, dvd_init, q_fix, r_fix, result;
    logic [CW-1:0]    count_init;
    logic [WIDTH:0]   trial;
    logic             op_unused;

    assign op_unused = &{1'b0, op[7:5]};

    always_comb begin
        op_signed = op[0];
        accept    = (state_reg == IDLE) && start && (op[4:2] == 3'b101);
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
        trial     = {rem_reg, dvd_reg[WIDTH-1]} - {1'b0, dsr_reg};
    end

`ifdef ALU_DIVIDER_EARLY_EXIT_EN
    logic [CW:0] lz;
    logic        found;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (a_mag[i]) found = 1'b1;
                else          lz = lz + (CW+1)'(1);
            end
        end
        dvd_init   = a_mag << lz;
        count_init = CW'(WIDTH - 1 - int'(lz));
        skip_run   = (a_mag == '0);
    end
`else
    always_comb begin
        dvd_init   = a_mag;
        count_init = CW'(WIDTH - 1);
        skip_run   = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = ((b == '0) || skip_run) ? FIX : RUN;
            RUN:  if (count_reg == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign fix-up: divide-by-zero quotient stays all ones, remainder keeps a's value.
    always_comb begin
        q_fix = (op_reg[0] && q_sign_reg) ? -dvd_reg : dvd_reg;
        if (dbz_reg) q_fix = '1;
        r_fix  = (op_reg[0] && r_sign_reg) ? -rem_reg : rem_reg;
        result = op_reg[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_reg          <= '0;
            dvd_reg         <= '0;
            dsr_reg         <= '0;
            rem_reg         <= '0;
            count_reg       <= '0;
            q_sign_reg      <= 1'b0;
            r_sign_reg      <= 1'b0;
            dbz_reg         <= 1'b0;
            c_reg           <= '0;
            is_zero_reg     <= 1'b1;
            is_negative_reg <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    op_reg     <= op[1:0];
                    dsr_reg    <= b_mag;
                    q_sign_reg <= a[WIDTH-1] ^ b[WIDTH-1];
                    r_sign_reg <= a[WIDTH-1];
                    dbz_reg    <= (b == '0);
                    count_reg  <= count_init;
                    dvd_reg    <= dvd_init;
                    rem_reg    <= (b == '0) ? a_mag : '0;
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem_reg <= trial[WIDTH-1:0];
                        dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
                        dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
                    end
                    count_reg <= count_reg - CW'(1);
                end
                FIX: begin
                    c_reg           <= result;
                    is_zero_reg     <= (result == '0);
                    is_negative_reg <= result[WIDTH-1];
                    div_by_zero_reg <= dbz_reg;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state_reg != IDLE);
        done        = (state_reg == DONE);
        c           = c_reg;
        is_zero     = is_zero_reg;
        is_negative = is_negative_reg;
        div_by_zero = div_by_zero_reg;
    end
endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed spec vectors, random ops against an arithmetic model.
// Honours ALU_DIVIDER_EARLY_EXIT_EN for the expected latency.
module tb_alu_divider;
    logic        clk = 1'b0;
    logic        resetn, start;
    logic [7:0]  op;
    logic [31:0] a, b, c;
    logic        busy, done, is_zero, is_negative, div_by_zero;
    int          checks = 0;
    int          errors = 0;

    alu_divider #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .c(c), .is_zero(is_zero),
        .is_negative(is_negative), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic with the divider's special cases.
    function automatic logic [31:0] model_c(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x;
        sy = y;
        if (y == 0) return (o[1]) ? x : 32'hFFFF_FFFF;
        if (!o[0]) return o[1] ? (x % y) : (x / y);
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    endfunction

    function automatic int model_lat(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mag;
        int bits;
        mag  = (o[0] && x[31]) ? -x : x;
        bits = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
        if (y == 0) return 2;
`ifdef ALU_DIVIDER_EARLY_EXIT_EN
        if (mag == 0) return 2;
        return bits + 2;
`else
        return 34 + 0 * bits;
`endif
    endfunction

    // Issue one op; lat = cycles from the accepting edge's cycle to done, -1 on timeout.
    task automatic do_op(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        $display("op=%0d a=%h b=%h c=%h zero=%b neg=%b dbz=%b lat=%0d", o, x, y, c, is_zero, is_negative, div_by_zero, lat);
    endtask

    task automatic check_op(input string name, input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat, elat;
        logic [31:0] ec;
        ec   = model_c(o, x, y);
        elat = model_lat(o, x, y);
        do_op(o, x, y, lat);
        checks++;
        if (c !== ec || is_zero !== (ec == 0) || is_negative !== ec[31] || div_by_zero !== (y == 0)) begin
            errors++;
            $display("FAIL %s result: got c=%h z=%b n=%b dbz=%b, expected c=%h z=%b n=%b dbz=%b",
                     name, c, is_zero, is_negative, div_by_zero, ec, ec == 0, ec[31], y == 0);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || c !== ec) begin
            errors++;
            $display("FAIL %s hold: got done=%b busy=%b c=%h expected 0 0 %h", name, done, busy, c, ec);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (c !== 0 || is_zero !== 1 || is_negative !== 0 || busy !== 0 || done !== 0 || div_by_zero !== 0) begin
            errors++;
            $display("FAIL reset: got c=%h z=%b n=%b busy=%b done=%b dbz=%b expected 0 1 0 0 0 0",
                     c, is_zero, is_negative, busy, done, div_by_zero);
        end
        resetn = 1'b1;
    endtask

    task automatic test_directed;
        check_op("divu", 8'd20, 32'd100, 32'd7);
        check_op("remu", 8'd22, 32'd100, 32'd7);
        check_op("div_neg", 8'd21, 32'hFFFF_FF9C, 32'd7);
        check_op("rem_neg", 8'd23, 32'hFFFF_FF9C, 32'd7);
        check_op("max_divisor", 8'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    endtask

    task automatic test_div_by_zero;
        check_op("dbz_divu", 8'd20, 32'h1234, 32'd0);
        check_op("dbz_remu", 8'd22, 32'h1234, 32'd0);
        check_op("dbz_rem_neg", 8'd23, 32'hFFFF_FF9C, 32'd0);
    endtask

    task automatic test_overflow;
        check_op("ovf_div", 8'd21, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("ovf_rem", 8'd23, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_random;
        logic [7:0]  o;
        logic [31:0] x, y;
        for (int n = 0; n < 40; n++) begin
            o = 8'(20 + $urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 0;
                1: y = $urandom_range(1, 15);
                2: x = $urandom_range(0, 255);
                3: y = -$urandom_range(1, 9);
                default: ;
            endcase
            check_op("random", o, x, y);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op = 8'd20; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        start = 1'b1; op = 8'd22; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; lat++;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        $display("op=20 a=%h b=%h (mid-run start ignored) c=%h lat=%0d", 32'd1000, 32'd3, c, lat);
        checks++;
        if (!done || c !== 32'd333 || lat != model_lat(8'd20, 32'd1000, 32'd3)) begin
            errors++;
            $display("FAIL mid_run_start: got done=%b c=%0d lat=%0d expected 1 333 %0d",
                     done, c, lat, model_lat(8'd20, 32'd1000, 32'd3));
        end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        @(posedge clk); #1;
        start = 1'b1; op = 8'd21; a = 32'hFFFF_0000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        checks++;
        if (c !== 0 || is_zero !== 1 || busy !== 0 || done !== 0 || div_by_zero !== 0 || is_negative !== 0) begin
            errors++;
            $display("FAIL reset_mid_run: got c=%h z=%b busy=%b done=%b expected 0 1 0 0", c, is_zero, busy, done);
        end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
        $display("reset mid-run: busy/done cycles afterwards=%0d", seen);
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_run_quiet: got %0d busy/done cycles expected 0", seen);
        end
    endtask

    task automatic test_bad_op;
        int seen;
        logic [31:0] c_before;
        c_before = c;
        @(posedge clk); #1;
        start = 1'b1; op = 8'd0; a = 32'd10; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        seen = (busy || done) ? 1 : 0;
        repeat (40) begin @(posedge clk); #1; if (busy || done) seen++; end
        $display("op=0 a=%h b=%h busy/done cycles=%0d c=%h", 32'd10, 32'd2, seen, c);
        checks++;
        if (seen != 0 || c !== c_before) begin
            errors++;
            $display("FAIL bad_op: got %0d busy/done cycles c=%h expected 0 and c=%h", seen, c, c_before);
        end
    endtask

    task automatic test_early_exit;
        check_op("small_dividend", 8'd20, 32'd5, 32'd2);
        check_op("zero_dividend", 8'd20, 32'd0, 32'd9);
        check_op("zero_dividend_signed", 8'd23, 32'd0, 32'hFFFF_FFF0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_div_by_zero;
        test_overflow;
        test_random;
        test_back_to_back;
        test_reset_mid_run;
        test_bad_op;
        test_early_exit;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
